// File: rtl/cam_pkg.sv
// Shared encodings for the camera test-pattern generator: pattern modes,
// controller states and the colour-bar lookup table.
package cam_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_FRAME = 2'd3
    } cam_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cam_state_e;

    // Index 0 is the leftmost bar.
    localparam logic [0:7][7:0] BAR_TABLE = {
        8'hFF, 8'hE0, 8'h1C, 8'hFC, 8'h03, 8'hE3, 8'h1F, 8'h00
    };

endpackage

// File: rtl/cam_timing_cnt.sv
// Pixel-clock prescaler and horizontal/vertical raster counters.
// All counters sit at zero whenever run is low.
module cam_timing_cnt
    import cam_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOTAL = 1600,
    parameter int unsigned V_TOTAL = 521
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        run,
    output logic                        pix_ce,
    output logic                        pclk,
    output logic [$clog2(H_TOTAL)-1:0]  h_cnt,
    output logic [$clog2(V_TOTAL)-1:0]  v_cnt
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;

    assign pix_ce = run && (presc == PRESC_LAST);

    always_comb begin
        presc_nxt = '0;
        if (run && !pix_ce) begin
            presc_nxt = presc + 1'b1;
        end
    end

    // pclk is registered from the next prescaler value so it is a clean flop output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc <= '0;
            pclk  <= 1'b0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            presc <= presc_nxt;
            pclk  <= (32'(presc_nxt) >= CLK_DIV / 2);
            if (!run) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (pix_ce) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// Camera-style test-pattern source: OV-like pclk/vsync/href/data timing
// with ramp, colour-bar, constant and frame-number patterns.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 1600,
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_TOTAL     = 521,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_START     = 31,
    parameter int unsigned V_ACTIVE    = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  const_val,
    output logic        cam_pclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned HW    = $clog2(H_TOTAL);
    localparam int unsigned VW    = $clog2(V_TOTAL);
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned BW    = $clog2(BAR_W + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    cam_state_e    state;
    cam_state_e    state_nxt;
    logic          run;
    logic          pix_ce;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    cam_mode_e     mode_sh;
    cam_mode_e     mode_use;
    logic [7:0]    const_sh;
    logic [7:0]    const_use;
    logic [7:0]    fnum_sh;
    logic [7:0]    fnum_use;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic          frame_first;
    logic          frame_last;
    logic          vsync_nxt;
    logic          href_nxt;
    logic [7:0]    data_nxt;

    cam_timing_cnt #(
        .CLK_DIV (CLK_DIV),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .pix_ce (pix_ce),
        .pclk   (cam_pclk),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // run drops combinationally with enable so the counters clear on the next edge.
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            ST_IDLE: if (enable) state_nxt = ST_RUN;
            ST_RUN: begin
                run = enable;
                if (!enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pixel (0,0) uses the live inputs; the rest of the frame uses the shadows.
    always_comb begin
        frame_first = (h_cnt == '0) && (v_cnt == '0);
        frame_last  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        mode_use    = frame_first ? cam_mode_e'(mode) : mode_sh;
        const_use   = frame_first ? const_val : const_sh;
        fnum_use    = frame_first ? frame_cnt[7:0] : fnum_sh;
        vsync_nxt   = (32'(v_cnt) < VSYNC_LINES);
        href_nxt    = (32'(v_cnt) >= V_START) && (32'(v_cnt) < V_START + V_ACTIVE) &&
                      (32'(h_cnt) < H_ACTIVE);
        data_nxt    = '0;
        case (mode_use)
            MODE_RAMP:  data_nxt = 8'(h_cnt);
            MODE_BARS:  data_nxt = BAR_TABLE[bar_idx];
            MODE_CONST: data_nxt = const_use;
            MODE_FRAME: data_nxt = fnum_use;
            default:    data_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            mode_sh     <= MODE_RAMP;
            const_sh    <= '0;
            fnum_sh     <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
        end else begin
            frame_start <= 1'b0;
            if (!run) begin
                cam_vsync <= 1'b0;
                cam_href  <= 1'b0;
                cam_data  <= '0;
                bar_px    <= '0;
                bar_idx   <= '0;
            end else if (pix_ce) begin
                cam_vsync   <= vsync_nxt;
                cam_href    <= href_nxt;
                cam_data    <= href_nxt ? data_nxt : '0;
                frame_start <= frame_first;
                if (frame_first) begin
                    mode_sh  <= cam_mode_e'(mode);
                    const_sh <= const_val;
                    fnum_sh  <= frame_cnt[7:0];
                end
                if (frame_last) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
                // Bar sub-counter tracks h_cnt so no divider is needed.
                if (h_cnt == H_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= '0;
                end else if (bar_px == BAR_LAST) begin
                    bar_px  <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_px <= bar_px + 1'b1;
                end
            end
        end
    end

endmodule
